// File: rtl/pin_entry_collector.sv
// pin_entry_collector
//
// Collects keypad strobes into a six-digit BCD display packet. The newest
// digit enters on the right and older digits shift left, as on a
// calculator. Backspace, an inactivity timeout and a minimum-length check
// are handled here, so the door-lock FSM downstream only sees complete PIN
// events.
//
// Ports:
//   clk, rst      clock (rising edge); asynchronous active-high reset
//   enable        low: strobes ignored, timer frozen, state/packet held
//   key_valid     one-cycle strobe qualifying key_code
//   key_code      0x0-0x9 digit, 0xA backspace, 0xB enter, 0xC-0xF ignored
//   bcd_packet    live packet; [23:20] rightmost digit .. [3:0] leftmost, 0xF = blank
//   digit_count   digits currently held (0..6)
//   pin_code      packet captured on a successful enter
//   pin_len       digit count captured with pin_code
//   pin_valid     one-cycle pulse: pin_code/pin_len updated
//   pin_error     one-cycle pulse: enter with too few digits
//   timeout       one-cycle pulse: entry abandoned on inactivity
//   entering      high while in ENTRY (this is the whole FSM state)
//
// Handshake: a key is consumed in the cycle key_valid && enable is high
// and key_code <= 0xB. There is no back-pressure; every qualifying strobe
// is acted on, including strobes on consecutive cycles.
module pin_entry_collector #(
  parameter int TIMEOUT_CYCLES = 250_000_000,
  parameter int MIN_DIGITS     = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  output logic [23:0] bcd_packet,
  output logic [2:0]  digit_count,
  output logic [23:0] pin_code,
  output logic [2:0]  pin_len,
  output logic        pin_valid,
  output logic        pin_error,
  output logic        timeout,
  output logic        entering
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  // The timeout pulse is registered, so the decision is taken one cycle
  // before the terminal count would be stored: the pulse is then high in
  // the cycle that starts TIMEOUT_CYCLES-1 edges after the last key.
  localparam logic [TW-1:0] TIMER_TERM = TW'(TIMEOUT_CYCLES - 2);
  localparam logic [2:0]    MIN_LEN    = 3'(MIN_DIGITS);
  localparam logic [23:0]   BLANK      = 24'hFFFFFF;

  typedef enum logic {IDLE = 1'b0, ENTRY = 1'b1} state_t;

  state_t        state_q, state_d;
  logic [23:0]   packet_q, packet_d;
  logic [2:0]    count_q, count_d;
  logic [23:0]   pin_code_q, pin_code_d;
  logic [2:0]    pin_len_q, pin_len_d;
  logic          pin_valid_q, pin_valid_d;
  logic          pin_error_q, pin_error_d;
  logic          timeout_q, timeout_d;
  logic [TW-1:0] timer_q, timer_d;

  logic accept;
  logic terminal;

  assign accept   = key_valid && enable && (key_code <= 4'hB);
  assign terminal = (state_q == ENTRY) && enable && (timer_q == TIMER_TERM);

  always_comb begin
    state_d     = state_q;
    packet_d    = packet_q;
    count_d     = count_q;
    pin_code_d  = pin_code_q;
    pin_len_d   = pin_len_q;
    pin_valid_d = 1'b0;
    pin_error_d = 1'b0;
    timeout_d   = 1'b0;
    timer_d     = timer_q;

    if (state_q == ENTRY && enable) begin
      timer_d = timer_q + 1'b1;
    end

    if (accept) begin
      if (key_code <= 4'h9) begin
        // A seventh digit is dropped, but the user is clearly active.
        timer_d = '0;
        if (count_q < 3'd6) begin
          packet_d = {key_code, packet_q[23:4]};
          count_d  = count_q + 3'd1;
          state_d  = ENTRY;
        end
      end else if (key_code == 4'hA) begin
        if (count_q != 3'd0) begin
          packet_d = {packet_q[19:0], 4'hF};
          count_d  = count_q - 3'd1;
          timer_d  = '0;
          if (count_q == 3'd1) begin
            state_d = IDLE;
          end
        end
      end else begin
        if (count_q >= MIN_LEN) begin
          pin_code_d  = packet_q;
          pin_len_d   = count_q;
          pin_valid_d = 1'b1;
        end else begin
          pin_error_d = 1'b1;
        end
        packet_d = BLANK;
        count_d  = 3'd0;
        timer_d  = '0;
        state_d  = IDLE;
      end
    end else if (terminal) begin
      // A key in the terminal cycle takes the branch above instead.
      timeout_d = 1'b1;
      packet_d  = BLANK;
      count_d   = 3'd0;
      timer_d   = '0;
      state_d   = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      packet_q    <= BLANK;
      count_q     <= 3'd0;
      pin_code_q  <= BLANK;
      pin_len_q   <= 3'd0;
      pin_valid_q <= 1'b0;
      pin_error_q <= 1'b0;
      timeout_q   <= 1'b0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      packet_q    <= packet_d;
      count_q     <= count_d;
      pin_code_q  <= pin_code_d;
      pin_len_q   <= pin_len_d;
      pin_valid_q <= pin_valid_d;
      pin_error_q <= pin_error_d;
      timeout_q   <= timeout_d;
      timer_q     <= timer_d;
    end
  end

  assign bcd_packet  = packet_q;
  assign digit_count = count_q;
  assign pin_code    = pin_code_q;
  assign pin_len     = pin_len_q;
  assign pin_valid   = pin_valid_q;
  assign pin_error   = pin_error_q;
  assign timeout     = timeout_q;
  assign entering    = (state_q == ENTRY);

endmodule

// File: tb/tb_pin_entry_collector.sv
// Directed bench for pin_entry_collector with TIMEOUT_CYCLES=16, MIN_DIGITS=4.
module tb_pin_entry_collector;

  logic        clk;
  logic        rst;
  logic        enable;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [23:0] bcd_packet;
  logic [2:0]  digit_count;
  logic [23:0] pin_code;
  logic [2:0]  pin_len;
  logic        pin_valid;
  logic        pin_error;
  logic        timeout;
  logic        entering;

  int n_checks;
  int n_errors;

  pin_entry_collector #(
    .TIMEOUT_CYCLES(16),
    .MIN_DIGITS    (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .bcd_packet (bcd_packet),
    .digit_count(digit_count),
    .pin_code   (pin_code),
    .pin_len    (pin_len),
    .pin_valid  (pin_valid),
    .pin_error  (pin_error),
    .timeout    (timeout),
    .entering   (entering)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=no_finish exp=finish");
    $fatal(1, "watchdog expired");
  end

  // Checker
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drivers: inputs change #1 after an edge, outputs sampled #1 after the next.
  task automatic step();
    @(posedge clk);
    #1;
    check("pulse_onehot", 32'($countones({pin_valid, pin_error, timeout}) <= 1), 32'd1);
  endtask

  task automatic press(input logic [3:0] code);
    key_valid = 1'b1;
    key_code  = code;
    step();
    key_valid = 1'b0;
    key_code  = 4'h0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_packet"},   32'(bcd_packet),  32'hFFFFFF);
    check({tag, "_count"},    32'(digit_count), 32'd0);
    check({tag, "_pin_code"}, 32'(pin_code),    32'hFFFFFF);
    check({tag, "_pin_len"},  32'(pin_len),     32'd0);
    check({tag, "_pulses"},   32'({pin_valid, pin_error, timeout}), 32'd0);
    check({tag, "_entering"}, 32'(entering),    32'd0);
  endtask

  int seen;

  initial begin
    n_checks  = 0;
    n_errors  = 0;
    rst       = 1'b1;
    enable    = 1'b1;
    key_valid = 1'b0;
    key_code  = 4'h0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst = 1'b0;
    step();

    // Four digits then enter
    press(4'h1); press(4'h2); press(4'h3);
    press(4'h4);
    check("t1_packet",   32'(bcd_packet),  32'h4321FF);
    check("t1_count",    32'(digit_count), 32'd4);
    check("t1_entering", 32'(entering),    32'd1);
    press(4'hB);
    check("t1_pin_valid", 32'(pin_valid),   32'd1);
    check("t1_pin_code",  32'(pin_code),    32'h4321FF);
    check("t1_pin_len",   32'(pin_len),     32'd4);
    check("t1_cleared",   32'(bcd_packet),  32'hFFFFFF);
    check("t1_count0",    32'(digit_count), 32'd0);
    check("t1_idle",      32'(entering),    32'd0);
    step();
    check("t1_pulse_end", 32'(pin_valid), 32'd0);

    // Overflow and backspace
    for (int d = 1; d <= 9; d++) press(4'(d));
    check("t2_count6",  32'(digit_count), 32'd6);
    check("t2_packet6", 32'(bcd_packet),  32'h654321);
    press(4'hA); press(4'hA);
    check("t2_bs2_packet", 32'(bcd_packet),  32'h4321FF);
    check("t2_bs2_count",  32'(digit_count), 32'd4);
    for (int i = 0; i < 4; i++) press(4'hA);
    check("t2_bs_count0",  32'(digit_count), 32'd0);
    check("t2_bs_idle",    32'(entering),    32'd0);
    press(4'hA);
    check("t2_bs_extra_count",  32'(digit_count), 32'd0);
    check("t2_bs_extra_packet", 32'(bcd_packet),  32'hFFFFFF);
    check("t2_bs_extra_pulses", 32'({pin_valid, pin_error, timeout}), 32'd0);

    // Short entry
    press(4'h7); press(4'h8);
    press(4'hB);
    check("t3_pin_error", 32'(pin_error),  32'd1);
    check("t3_no_valid",  32'(pin_valid),  32'd0);
    check("t3_pin_code",  32'(pin_code),   32'h4321FF);
    check("t3_pin_len",   32'(pin_len),    32'd4);
    check("t3_cleared",   32'(bcd_packet), 32'hFFFFFF);
    step();
    check("t3_pulse_end", 32'(pin_error), 32'd0);
    press(4'hB);
    check("t3_idle_enter_error", 32'(pin_error), 32'd1);
    step();

    // Timeout 15 cycles after the accepting edge; codes C-F do not reset it
    press(4'h5);
    seen = 0;
    for (int j = 1; j <= 14; j++) begin
      if (j <= 4) begin
        key_valid = 1'b1;
        key_code  = 4'(4'hB + j);
      end
      step();
      key_valid = 1'b0;
      key_code  = 4'h0;
      if (timeout) seen++;
      if (j == 4) check("t4_ignored_codes", 32'(bcd_packet), 32'h5FFFFF);
    end
    check("t4_no_early_timeout", 32'(seen), 32'd0);
    step();
    check("t4_timeout",  32'(timeout),     32'd1);
    check("t4_cleared",  32'(bcd_packet),  32'hFFFFFF);
    check("t4_count0",   32'(digit_count), 32'd0);
    check("t4_idle",     32'(entering),    32'd0);
    step();
    check("t4_pulse_end", 32'(timeout), 32'd0);

    // Key in the terminal cycle wins
    press(4'h5);
    for (int j = 1; j <= 14; j++) step();
    press(4'h6);
    check("t4b_no_timeout", 32'(timeout),     32'd0);
    check("t4b_count",      32'(digit_count), 32'd2);
    check("t4b_packet",     32'(bcd_packet),  32'h65FFFF);
    step();
    check("t4b_still_none", 32'(timeout), 32'd0);
    press(4'hB);
    check("t4b_short_enter", 32'(pin_error), 32'd1);
    step();

    // enable low freezes timer and blocks keys
    press(4'h5);
    for (int j = 1; j <= 5; j++) step();
    enable    = 1'b0;
    key_valid = 1'b1;
    key_code  = 4'h9;
    seen = 0;
    for (int j = 0; j < 40; j++) begin
      step();
      if (timeout) seen++;
    end
    check("t5_frozen_packet", 32'(bcd_packet),  32'h5FFFFF);
    check("t5_frozen_count",  32'(digit_count), 32'd1);
    key_valid = 1'b0;
    key_code  = 4'h0;
    enable    = 1'b1;
    for (int j = 1; j <= 9; j++) begin
      step();
      if (timeout) seen++;
    end
    check("t5_no_timeout_yet", 32'(seen), 32'd0);
    step();
    check("t5_timeout",  32'(timeout),    32'd1);
    check("t5_cleared",  32'(bcd_packet), 32'hFFFFFF);
    step();

    // Asynchronous reset mid-entry
    press(4'h7); press(4'h8);
    #3;
    rst = 1'b1;
    #1;
    check_reset_values("rst_async");
    @(posedge clk);
    #1;
    check_reset_values("rst_held");
    rst = 1'b0;
    press(4'h3);
    check("rst_after_packet", 32'(bcd_packet), 32'h3FFFFF);
    check("rst_after_count",  32'(digit_count), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pin_entry_collector.md
# pin_entry_collector

Collects keypad key strobes into a six-digit BCD packet for the 7-segment display controller and captures the final PIN on enter. Sits between the keypad scanner/debouncer and the door-lock FSM. Digits enter from the right and shift left, as on a calculator. Backspace, an inactivity timeout and a minimum-length check are handled here, so the lock FSM only sees complete PIN events.

## Interface
- TIMEOUT_CYCLES, 250_000_000: idle cycles after the last accepted key before entry is abandoned (5 s at 50 MHz); must be ≥2.
- MIN_DIGITS, 4: minimum digit count accepted on enter; legal range 1..6.
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- enable  in  1  when low, key strobes are ignored and the timeout counter holds; state and packet are kept.
- key_valid  in  1  one-cycle strobe, key_code valid.
- key_code  in  4  0x0–0x9 digit; 0xA backspace; 0xB enter; 0xC–0xF ignored.
- bcd_packet  out  24  live display packet (bcdPac_t layout): [23:20] rightmost digit (HEX0) … [3:0] leftmost (HEX5); 0xF = blank.
- digit_count  out  3  digits currently held, 0..6.
- pin_code  out  24  packet captured on successful enter, same layout; held until next success.
- pin_len  out  3  digit_count captured with pin_code.
- pin_valid  out  1  one-cycle pulse, pin_code/pin_len updated.
- pin_error  out  1  one-cycle pulse, enter with digit_count < MIN_DIGITS.
- timeout  out  1  one-cycle pulse, entry abandoned on inactivity.
- entering  out  1  high while state is ENTRY.

## Operation
- Reset values: bcd_packet 0xFFFFFF, digit_count 0, pin_code 0xFFFFFF, pin_len 0, pin_valid/pin_error/timeout 0, entering 0, state IDLE, timer 0.
- States: IDLE (digit_count 0, timer stopped) and ENTRY (digit_count ≥1, timer running).
- A key is accepted only when key_valid=1, enable=1 and the code is 0x0–0xB. All other strobes are ignored and do not touch the timer.
- Digit, count<6: slot0 ← digit, slotN ← slot(N-1), count+1, timer cleared. IDLE→ENTRY.
- Digit, count=6: dropped, with no state change. Timer is still cleared, because the user is active.
- Backspace, count≥1: slotN ← slot(N+1), slot5 ← 0xF, count−1, timer cleared. Count reaching 0 → IDLE.
- Backspace, count=0: ignored.
- Enter, count ≥ MIN_DIGITS: pin_code ← bcd_packet, pin_len ← count, pulse pin_valid, then clear packet to 0xFFFFFF, count 0, → IDLE.
- Enter, count < MIN_DIGITS (including 0): pulse pin_error, clear packet and count, → IDLE. pin_code and pin_len are unchanged.
- Timeout: in ENTRY with enable=1, the timer increments each cycle. When timer = TIMEOUT_CYCLES−1 with no accepted key that cycle: pulse timeout, clear packet and count, → IDLE. The timeout pulse is not issued from IDLE.
- Timer width is $clog2(TIMEOUT_CYCLES). It never wraps; it is cleared on any exit from ENTRY.

## Timing
- All outputs are registered. An effect of a key sampled at edge k is visible after edge k (one-cycle latency from strobe).
- Pulses (pin_valid, pin_error, timeout) are high exactly one cycle. At most one is high in any cycle.
- pin_code/pin_len change in the same cycle pin_valid is high.
- Key accepted in the same cycle the timer reaches terminal count: the key wins, it is processed, the timer is cleared and no timeout is issued.
- enable low in ENTRY: the timer freezes and resumes at the held value when enable returns.
- Back-to-back strobes on consecutive cycles are all accepted.
- rst asserted mid-entry: all outputs return immediately to reset values, including pin_code. No pulse is emitted.

## Test plan
- Reset, then keys 1,2,3,4 → bcd_packet 0x4321FF ([23:20]=4), digit_count 4, entering 1; enter → pin_valid one cycle, pin_code 0x4321FF, pin_len 4, bcd_packet 0xFFFFFF.
- Keys 1..9 (nine digits) → digit_count 6, bcd_packet 0x654321; backspace ×2 → 0x4321FF, count 4; backspace ×5 → count 0, entering 0, the fifth ignored.
- Keys 7,8 then enter (MIN_DIGITS=4) → pin_error one cycle, pin_code unchanged from prior value, packet cleared; enter from IDLE → pin_error.
- TIMEOUT_CYCLES=16: key 5, idle → timeout high exactly 15 cycles after the accepting edge, packet cleared. Repeat with a key at the terminal cycle → no timeout, count 2.
- enable=0 during ENTRY for 40 cycles (TIMEOUT_CYCLES=16) with strobes of digit 9 → packet unchanged, no timeout; enable=1 → timeout after the remaining cycles.
- Codes 0xC–0xF strobed in ENTRY → no change, timer not cleared; rst pulsed mid-entry → all outputs at reset values the next sample.
